// File: rtl/branch_cmp_iter_pkg.sv
// Shared op-codes, FSM states and outcome helpers
// for the iterative branch comparator.
package branch_cmp_iter_pkg;

  localparam logic [2:0] CMP_EQ  = 3'd0;
  localparam logic [2:0] CMP_NE  = 3'd1;
  localparam logic [2:0] CMP_LEZ = 3'd2;
  localparam logic [2:0] CMP_GTZ = 3'd3;
  localparam logic [2:0] CMP_LTZ = 3'd4;
  localparam logic [2:0] CMP_GEZ = 3'd5;
  localparam logic [2:0] CMP_LTS = 3'd6;
  localparam logic [2:0] CMP_LTU = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_zero_mode(
    input logic [2:0] op
  );
    return (op >= CMP_LEZ) && (op <= CMP_GEZ);
  endfunction

  function automatic logic is_signed_mode(
    input logic [2:0] op
  );
    return (op >= CMP_LEZ) && (op <= CMP_LTS);
  endfunction

  function automatic logic outcome(
    input logic [2:0] op,
    input logic       eq,
    input logic       lt
  );
    logic r;
    unique case (op)
      CMP_EQ:  r = eq;
      CMP_NE:  r = !eq;
      CMP_LEZ: r = lt | eq;
      CMP_GTZ: r = !(lt | eq);
      CMP_LTZ: r = lt;
      CMP_GEZ: r = !lt;
      default: r = lt;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_cmp_iter_cmp_chunk.sv
// One CHUNK-bit slice compare; the top slice of a
// signed compare flips the sign bits to order two's complement.
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             signed_top,
  output logic             eq,
  output logic             lt
);

  logic [CHUNK-1:0] a_m;
  logic [CHUNK-1:0] b_m;

  always_comb begin
    a_m = a;
    b_m = b;
    if (signed_top) begin
      a_m[CHUNK-1] = ~a[CHUNK-1];
      b_m[CHUNK-1] = ~b[CHUNK-1];
    end
  end

  assign eq = (a == b);
  assign lt = (a_m < b_m);

endmodule

// File: rtl/branch_cmp_iter.sv
// Multi-cycle MSB-first branch comparator with
// start/busy/done handshake, early exit and flush.
module branch_cmp_iter
  import branch_cmp_iter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             taken
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW =
    (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] TOP =
    IW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of CHUNK");
  end

  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, a_n;
  logic [WIDTH-1:0] b_q, b_n;
  logic [2:0]       op_q, op_n;
  logic [IW-1:0]    idx, idx_n;
  logic             eq_acc, eq_n;
  logic             lt_acc, lt_n;
  logic             taken_q, taken_n;

  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic             c_eq;
  logic             c_lt;
  logic             s_top;
  logic             eq_new;
  logic             lt_new;
  logic             last;

  assign a_c   = a_q[CHUNK*int'(idx) +: CHUNK];
  assign b_c   = b_q[CHUNK*int'(idx) +: CHUNK];
  assign s_top = (idx == TOP) &&
                 is_signed_mode(op_q);

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a          (a_c),
    .b          (b_c),
    .signed_top (s_top),
    .eq         (c_eq),
    .lt         (c_lt)
  );

  // The first differing chunk decides lt; later chunks are ignored.
  assign eq_new = eq_acc & c_eq;
  assign lt_new = (eq_acc && !c_eq) ?
                  c_lt : lt_acc;
  assign last   = (idx == '0) ||
                  ((EARLY_EXIT != 0) && !c_eq);

  always_comb begin
    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    idx_n   = idx;
    eq_n    = eq_acc;
    lt_n    = lt_acc;
    taken_n = taken_q;
    unique case (state)
      IDLE: begin
        if (start && !flush) begin
          state_n = RUN;
          a_n     = in_a;
          b_n     = is_zero_mode(op) ?
                    '0 : in_b;
          op_n    = op;
          idx_n   = TOP;
          eq_n    = 1'b1;
          lt_n    = 1'b0;
          taken_n = 1'b0;
        end
      end
      RUN: begin
        if (flush) begin
          state_n = IDLE;
        end else begin
          eq_n = eq_new;
          lt_n = lt_new;
          if (last) begin
            state_n = DONE;
            taken_n = outcome(op_q, eq_new,
                              lt_new);
          end else begin
            idx_n = idx - 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      idx     <= '0;
      eq_acc  <= 1'b0;
      lt_acc  <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state   <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      op_q    <= op_n;
      idx     <= idx_n;
      eq_acc  <= eq_n;
      lt_acc  <= lt_n;
      taken_q <= taken_n;
    end
  end

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign taken = taken_q;

endmodule
